// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter controller: the counter
// width, the command and select encodings, and the controller FSM states.
package perf_pkg;

    localparam int CNT_W   = 20;
    localparam int NUM_REQ = 2;
    localparam int NUM_EV  = 3;

    typedef enum logic [1:0] {
        CMD_READ  = 2'd0,
        CMD_START = 2'd1,
        CMD_STOP  = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_e;

    localparam logic [1:0] SEL_INSTR = 2'd0;
    localparam logic [1:0] SEL_MEM   = 2'd1;
    localparam logic [1:0] SEL_CORR  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/perf_rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the last winner; on a
// tie the other port wins. The pointer only advances when a grant is given.
module perf_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic last_reg;
    logic win_id;

    // Pick the winner and drive a one-hot grant while enabled.
    always_comb begin
        win_id = 1'b0;
        if (req == 2'b11) begin
            win_id = ~last_reg;
        end else begin
            win_id = req[1];
        end
        grant = 2'b00;
        if (en && (req != 2'b00)) begin
            grant = win_id ? 2'b10 : 2'b01;
        end
        grant_id = win_id;
    end

    // Remember the last winner; reset to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_reg <= 1'b1;
        end else if (en && (req != 2'b00)) begin
            last_reg <= win_id;
        end
    end

endmodule

// File: rtl/perf_ctr_ctrl.sv
// Performance-counter bank controller: gates raw event pulses into the bank,
// starts/stops/clears counting and serves counter reads for two requesters
// (port 0 CPU, port 1 debug) with one command in flight at a time.
// Optional build macro PERF_CTR_OVF_EN adds per-counter sticky overflow flags
// reported on rsp_ovf; without it rsp_ovf is constant 0.
module perf_ctr_ctrl
    import perf_pkg::*;
#(
    parameter int CNT_W   = perf_pkg::CNT_W,
    parameter int NUM_REQ = perf_pkg::NUM_REQ
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [2*NUM_REQ-1:0] req_cmd,
    input  logic [2*NUM_REQ-1:0] req_sel,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [CNT_W-1:0]     rsp_data,
    output logic                 rsp_err,
    output logic                 rsp_ovf,
    input  logic                 ev_instr_in,
    input  logic                 ev_mem_in,
    input  logic                 ev_corr_in,
    output logic                 ev_instr_out,
    output logic                 ev_mem_out,
    output logic                 ev_corr_out,
    output logic                 ctr_rst,
    input  logic [CNT_W-1:0]     cnt_instr,
    input  logic [CNT_W-1:0]     cnt_mem,
    input  logic [CNT_W-1:0]     cnt_corr,
    output logic                 counting
);

    state_e             state_reg;
    state_e             state_next;
    cmd_e               cmd_reg;
    logic [1:0]         sel_reg;
    logic               rsp_id_reg;
    logic               ctr_rst_reg;
    logic               counting_reg;
    logic [CNT_W-1:0]   rsp_data_reg;
    logic               rsp_err_reg;

    logic               arb_en;
    logic [1:0]         grant;
    logic               grant_id;
    logic               hs;
    logic [1:0]         win_cmd;
    logic [1:0]         win_sel;
    logic [CNT_W-1:0]   rd_data;

    logic [NUM_EV-1:0]  ev_in_vec;
    logic [NUM_EV-1:0]  ev_out_vec;

    // Grants are only offered while idle and never while reset is held.
    assign arb_en = (state_reg == ST_IDLE) && !reset;

    perf_rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .en       (arb_en),
        .req      (req_valid),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready = grant;
    assign hs        = |(req_valid & grant);
    assign win_cmd   = req_cmd[{grant_id, 1'b0} +: 2];
    assign win_sel   = req_sel[{grant_id, 1'b0} +: 2];

    // Event gating: drop raw events while stopped or while the bank is cleared.
    assign ev_in_vec = {ev_corr_in, ev_mem_in, ev_instr_in};
    generate
        for (genvar gi = 0; gi < NUM_EV; gi++) begin : g_gate
            assign ev_out_vec[gi] = ev_in_vec[gi] & counting_reg & ~ctr_rst_reg;
        end
    endgenerate
    assign ev_instr_out = ev_out_vec[0];
    assign ev_mem_out   = ev_out_vec[1];
    assign ev_corr_out  = ev_out_vec[2];

    // Select the live bank value addressed by the latched READ select.
    always_comb begin
        rd_data = '0;
        case (sel_reg)
            SEL_INSTR: rd_data = cnt_instr;
            SEL_MEM:   rd_data = cnt_mem;
            SEL_CORR:  rd_data = cnt_corr;
            default:   rd_data = '0;
        endcase
    end

    // Next-state logic: IDLE -> EXEC on handshake, EXEC -> RESP, RESP -> IDLE on accept.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (hs) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Command latch at handshake; the clear pulse covers only the cycle after it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_reg     <= CMD_READ;
            sel_reg     <= 2'd0;
            rsp_id_reg  <= 1'b0;
            ctr_rst_reg <= 1'b0;
        end else begin
            ctr_rst_reg <= hs && (cmd_e'(win_cmd) == CMD_CLEAR);
            if (hs) begin
                cmd_reg    <= cmd_e'(win_cmd);
                sel_reg    <= win_sel;
                rsp_id_reg <= grant_id;
            end
        end
    end

    // Execute: update counting enable and capture the response payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counting_reg <= 1'b0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else if (state_reg == ST_EXEC) begin
            if (cmd_reg == CMD_START) counting_reg <= 1'b1;
            if (cmd_reg == CMD_STOP)  counting_reg <= 1'b0;
            rsp_data_reg <= (cmd_reg == CMD_READ) ? rd_data : '0;
            rsp_err_reg  <= (cmd_reg == CMD_READ) && (sel_reg == 2'd3);
        end
    end

`ifdef PERF_CTR_OVF_EN
    logic [CNT_W-1:0]  cnt_arr [NUM_EV];
    logic [NUM_EV-1:0] ovf_flag_reg;
    logic              ovf_sel;
    logic              rsp_ovf_reg;

    assign cnt_arr[0] = cnt_instr;
    assign cnt_arr[1] = cnt_mem;
    assign cnt_arr[2] = cnt_corr;

    // Sticky flags: set when a gated event hits an all-ones counter, cleared with the bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_flag_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_EV; i++) begin
                if (ctr_rst_reg) begin
                    ovf_flag_reg[i] <= 1'b0;
                end else if (ev_out_vec[i] && (&cnt_arr[i])) begin
                    ovf_flag_reg[i] <= 1'b1;
                end
            end
        end
    end

    // Pick the flag of the selected counter; an illegal select reports none.
    always_comb begin
        ovf_sel = 1'b0;
        case (sel_reg)
            SEL_INSTR: ovf_sel = ovf_flag_reg[0];
            SEL_MEM:   ovf_sel = ovf_flag_reg[1];
            SEL_CORR:  ovf_sel = ovf_flag_reg[2];
            default:   ovf_sel = 1'b0;
        endcase
    end

    // Capture the overflow status alongside the READ data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_ovf_reg <= 1'b0;
        end else if (state_reg == ST_EXEC) begin
            rsp_ovf_reg <= (cmd_reg == CMD_READ) && ovf_sel;
        end
    end

    assign rsp_ovf = rsp_ovf_reg;
`else
    assign rsp_ovf = 1'b0;
`endif

    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;
    assign ctr_rst   = ctr_rst_reg;
    assign counting  = counting_reg;

endmodule

// File: doc/perf_ctr_ctrl.md
Name: perf_ctr_ctrl

Overview:
- Controller for the 20-bit performance-counter bank (instruction, memory-access and memory-correction counters).
- Gates raw event pulses into the bank, starts, stops and clears counting, and serves counter reads.
- Two requesters share the bank through round-robin arbitration: port 0 is the CPU, port 1 is the debug unit.
- One command is in flight at a time; responses use a valid/ready handshake.

Parameters:
- CNT_W, 20: counter width; must match the bank.
- NUM_REQ, 2: number of requesters; fixed at 2 in this revision.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester command valid
- req_cmd  in  4  2 bits per requester: 0 READ, 1 START, 2 STOP, 3 CLEAR
- req_sel  in  4  2 bits per requester, READ only: 0 instr, 1 mem, 2 corr, 3 illegal
- req_ready  out  2  per-requester accept
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  1  requester index of the response
- rsp_data  out  CNT_W  counter snapshot for READ; 0 for other commands
- rsp_err  out  1  illegal select
- rsp_ovf  out  1  sticky overflow of the selected counter (optional feature)
- ev_instr_in, ev_mem_in, ev_corr_in  in  1 each  raw event pulses
- ev_instr_out, ev_mem_out, ev_corr_out  out  1 each  gated pulses to the bank
- ctr_rst  out  1  registered clear pulse to the bank
- cnt_instr, cnt_mem, cnt_corr  in  CNT_W each  live bank values
- counting  out  1  counting-enabled status

Behaviour:
- Reset values:
  - FSM = IDLE, counting = 0, req_ready = 0, rsp_valid = 0, rsp_id = 0.
  - rsp_data = 0, rsp_err = 0, rsp_ovf = 0, ctr_rst = 0.
  - Round-robin pointer = 1, so port 0 wins the first tie.
- Event gating (combinational): ev_X_out = ev_X_in & counting & ~ctr_rst.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - req_ready is driven combinationally, one-hot, to the arbiter winner only; it is 0 in every other state.
  - Arbiter: if only one port is valid, that port wins; if both are valid, the port other than the last winner wins.
  - Handshake in cycle T (valid & ready): latch cmd, sel and id; update the pointer; go to EXEC.
  - If the command is CLEAR, ctr_rst is registered high for exactly cycle T+1.
- EXEC (cycle T+1):
  - START sets counting = 1 and STOP clears it; the new value is visible from T+2.
  - READ captures the selected cnt_* into rsp_data at the T+1 -> T+2 edge.
  - READ with sel = 3 gives rsp_err = 1 and rsp_data = 0.
  - Next state is RESP.
- RESP (from T+2):
  - rsp_valid = 1; rsp_id, rsp_data, rsp_err and rsp_ovf are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: return to IDLE. A new grant is possible in that same cycle's successor, so minimum command spacing is 3 cycles.
- Boundary conditions:
  - CLEAR: raw events arriving during the ctr_rst cycle are dropped. CLEAR does not change counting.
  - START while counting, or STOP while stopped: no-op, response still issued.
  - Wrap-around: the bank wraps naturally at 2^CNT_W; the controller does not saturate.
  - A requester that drops req_valid before the handshake loses its grant with no state change.
  - Reset mid-command: the command is aborted, the response is discarded and ctr_rst goes low immediately.

Optional Feature:
- Macro: PERF_CTR_OVF_EN.
- With the macro:
  - Per-counter sticky overflow flags are set when cnt_X is all-ones and ev_X_out = 1.
  - The flags clear on reset or CLEAR (clearing in cycle T+1).
  - READ returns the selected flag on rsp_ovf.
- Without the macro: no flag registers; rsp_ovf is tied to 0.

Decomposition:
- Shared package perf_pkg:
  - CNT_W.
  - Command enum: CMD_READ, CMD_START, CMD_STOP, CMD_CLEAR.
  - Select constants: SEL_INSTR, SEL_MEM, SEL_CORR.
  - FSM state enum.
- Sub-module perf_rr_arb2: 2-way round-robin arbiter with a pointer register, enabled only in IDLE.

Test Plan:
- Reset, then port 0 START; raise ev_instr_in for 5 cycles -> rsp_valid at T+2 with id 0; counting = 1 from T+2; 5 gated pulses reach the bank.
- Both ports valid at once (port 0 READ sel 1, port 1 READ sel 0) -> port 0 is served first. Repeat both valid -> port 1 is served. rsp_data equals the cnt value sampled at T+1.
- Port 1 CLEAR while ev_mem_in is held high -> ctr_rst high for exactly one cycle, ev_mem_out low in that cycle, rsp_data = 0.
- READ with sel = 3 -> rsp_err = 1, rsp_data = 0; hold rsp_ready low for 4 cycles -> response stable and req_ready stays 0.
- PERF_CTR_OVF_EN defined: cnt_corr = 0xFFFFF with ev_corr_in pulsed -> READ sel 2 returns rsp_ovf = 1; after CLEAR, READ returns rsp_ovf = 0.
- Assert reset during RESP -> all outputs at reset values next cycle; the next command is granted normally.
